// File: rtl/triumph_pkg.sv
// Shared constants and types for the integer register-file writeback controller.
package triumph_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned ADDR_W_DEFAULT = 5;
    localparam int unsigned NUM_REGS       = 2 ** ADDR_W_DEFAULT;
    localparam int unsigned REG_ZERO       = 0;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] rd;
        logic [DATA_W_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/triumph_wb_fifo.sv
// Small shift-register FIFO holding EX results; slot 0 is always the head, so
// the valid bits are a thermometer of the count and every rd is visible for hazards.
module triumph_wb_fifo
    import triumph_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter type         entry_t   = wb_entry_t,
    localparam int unsigned CntW     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  entry_t                           push_entry_i,
    input  logic                             pop_i,
    output entry_t                           head_o,
    output logic [CntW-1:0]                  count_o,
    output logic [BUF_DEPTH-1:0][ADDR_W-1:0] rd_o,
    output logic [BUF_DEPTH-1:0]             valid_o
);

    entry_t [BUF_DEPTH-1:0] mem_q, mem_d;
    logic   [CntW-1:0]      cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop_i && (cnt_q != '0)) begin
            for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            cnt_d = cnt_q - CntW'(1);
        end
        // Push lands after any pop, so a simultaneous push/pop keeps the count.
        if (push_i && (cnt_d < CntW'(BUF_DEPTH))) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                if (CntW'(i) == cnt_d) begin
                    mem_d[i] = push_entry_i;
                end
            end
            cnt_d = cnt_d + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            rd_o[i]    = mem_q[i].rd;
            valid_o[i] = CntW'(i) < cnt_q;
        end
    end

    assign head_o  = mem_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/triumph_wb_ctrl.sv
// Register-file write-port owner: arbitrates LSU loads over buffered EX results,
// tracks outstanding loads and reports RAW/WAW hazards to decode.
module triumph_wb_ctrl
    import triumph_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ex_valid_i,
    output logic                   ex_ready_o,
    input  logic [ADDR_W-1:0]      ex_rd_i,
    input  logic [DATA_W-1:0]      ex_data_i,
    input  logic                   lsu_valid_i,
    input  logic [ADDR_W-1:0]      lsu_rd_i,
    input  logic [DATA_W-1:0]      lsu_data_i,
    input  logic                   pend_set_i,
    input  logic [ADDR_W-1:0]      pend_rd_i,
    input  logic [ADDR_W-1:0]      id_rs1_i,
    input  logic [ADDR_W-1:0]      id_rs2_i,
    input  logic [ADDR_W-1:0]      id_rd_i,
    output logic                   hazard_o,
    output logic [2**ADDR_W-1:0]   pend_mask_o,
    output logic                   rf_we_o,
    output logic [ADDR_W-1:0]      rf_waddr_o,
    output logic [DATA_W-1:0]      rf_wdata_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam int unsigned CntW    = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                           fifo_head, push_entry, sel;
    logic   [CntW-1:0]                fifo_cnt;
    logic   [BUF_DEPTH-1:0][ADDR_W-1:0] fifo_rd;
    logic   [BUF_DEPTH-1:0]           fifo_valid;
    logic                             push, pop, sel_valid;
    logic                             lsu_wr, ex_wr, fifo_busy;
    logic                             rf_we_q, rf_we_d;
    logic   [ADDR_W-1:0]              rf_waddr_q, rf_waddr_d;
    logic   [DATA_W-1:0]              rf_wdata_q, rf_wdata_d;
    logic   [NumRegs-1:0]             pend_q, pend_d;
    logic   [2:0][ADDR_W-1:0]         id_idx;

    triumph_wb_fifo #(
        .BUF_DEPTH (BUF_DEPTH),
        .ADDR_W    (ADDR_W),
        .entry_t   (entry_t)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (fifo_head),
        .count_o      (fifo_cnt),
        .rd_o         (fifo_rd),
        .valid_o      (fifo_valid)
    );

    // Registered count only: a pop this cycle does not free a slot until next cycle.
    assign ex_ready_o = rst_i && (fifo_cnt < CntW'(BUF_DEPTH));

    always_comb begin
        lsu_wr     = lsu_valid_i && (lsu_rd_i != ZeroIdx);
        ex_wr      = ex_valid_i && ex_ready_o && (ex_rd_i != ZeroIdx);
        fifo_busy  = fifo_cnt != '0;
        push_entry = '{rd: ex_rd_i, data: ex_data_i};
        push       = ex_wr && (lsu_wr || fifo_busy);
        pop        = 1'b0;
        sel_valid  = 1'b0;
        sel        = '0;
        if (lsu_wr) begin
            sel_valid = 1'b1;
            sel       = '{rd: lsu_rd_i, data: lsu_data_i};
        end else if (fifo_busy) begin
            sel_valid = 1'b1;
            sel       = fifo_head;
            pop       = 1'b1;
        end else if (ex_wr) begin
            sel_valid = 1'b1;
            sel       = push_entry;
        end
    end

    always_comb begin
        rf_we_d    = sel_valid;
        rf_waddr_d = sel_valid ? sel.rd : rf_waddr_q;
        rf_wdata_d = sel_valid ? sel.data : rf_wdata_q;
        pend_d     = pend_q;
        if (lsu_wr) begin
            pend_d[lsu_rd_i] = 1'b0;
        end
        // Applied after the clear so a fresh load to the same register stays pending.
        if (pend_set_i && (pend_rd_i != ZeroIdx)) begin
            pend_d[pend_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pend_q     <= pend_d;
        end
    end

    assign id_idx = {id_rd_i, id_rs2_i, id_rs1_i};

    // The RF read port still returns the old value during the write cycle,
    // so the register being written right now also counts as a hazard.
    always_comb begin
        hazard_o = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (id_idx[s] != ZeroIdx) begin
                if (pend_q[id_idx[s]]) begin
                    hazard_o = 1'b1;
                end
                if (rf_we_q && (rf_waddr_q == id_idx[s])) begin
                    hazard_o = 1'b1;
                end
                for (int e = 0; e < int'(BUF_DEPTH); e++) begin
                    if (fifo_valid[e] && (fifo_rd[e] == id_idx[s])) begin
                        hazard_o = 1'b1;
                    end
                end
            end
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign pend_mask_o = pend_q;

endmodule
